// File: rtl/frame_buf_ctrl.sv
// Ping-pong frame buffer address sequencer: one writer and one reader share two
// frame-sized banks, and banks swap only when a read frame starts, so the display never tears.
module frame_buf_ctrl #(
  parameter int unsigned FRAME_SIZE = 307200,
  parameter int unsigned ADDR_WIDTH = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  input  logic                  wr_sof,
  input  logic                  rd_valid,
  input  logic                  rd_sof,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  output logic                  rd_blank,
  output logic                  frame_drop,
  output logic                  frame_repeat,
  output logic                  wr_short
);

  localparam int unsigned        OFF_W    = ADDR_WIDTH - 1;
  localparam logic [OFF_W-1:0]   LAST_OFF = OFF_W'(FRAME_SIZE - 1);
  localparam logic [OFF_W-1:0]   OFF_ONE  = OFF_W'(1);
  localparam logic [OFF_W-1:0]   OFF_ZERO = '0;

  typedef enum logic {WR_IDLE, WR_FILL} wr_state_e;
  typedef enum logic {RD_IDLE, RD_SCAN} rd_state_e;

  wr_state_e             wr_state_q, wr_state_d;
  rd_state_e             rd_state_q, rd_state_d;
  logic [OFF_W-1:0]      wr_off_q, wr_off_d;
  logic [OFF_W-1:0]      rd_off_q, rd_off_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [1:0]            full_q, full_d;
  logic                  rd_blank_q, rd_blank_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  drop_q, drop_d;
  logic                  repeat_q, repeat_d;
  logic                  short_q, short_d;
  logic                  rd_go;
  logic                  wr_bank;

  always_comb begin
    // NOTE: every signal gets a default first, so no path through this block infers a latch.
    rd_state_d = rd_state_q;
    rd_off_d   = rd_off_q;
    rd_bank_d  = rd_bank_q;
    rd_blank_d = rd_blank_q;
    full_d     = full_q;
    rd_en_d    = 1'b0;
    rd_addr_d  = rd_addr_q;
    repeat_d   = 1'b0;
    rd_go      = 1'b0;
    wr_state_d = wr_state_q;
    wr_off_d   = wr_off_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    drop_d     = 1'b0;
    short_d    = 1'b0;

    if (rd_valid && rd_sof) begin
      if (full_q[~rd_bank_q]) begin
        rd_bank_d           = ~rd_bank_q;
        full_d[~rd_bank_q]  = 1'b0;
        rd_blank_d          = 1'b0;
        rd_go               = 1'b1;
      end else if (!rd_blank_q) begin
        repeat_d = 1'b1;
        rd_go    = 1'b1;
      end else begin
        rd_state_d = RD_IDLE;
      end
      if (rd_go) begin
        rd_en_d    = 1'b1;
        rd_addr_d  = {rd_bank_d, OFF_ZERO};
        rd_off_d   = OFF_ONE;
        rd_state_d = RD_SCAN;
      end
    end else if (rd_valid && rd_state_q == RD_SCAN) begin
      rd_en_d   = 1'b1;
      rd_addr_d = {rd_bank_q, rd_off_q};
      if (rd_off_q == LAST_OFF) begin
        rd_off_d   = OFF_ZERO;
        rd_state_d = RD_IDLE;
      end else begin
        rd_off_d = rd_off_q + OFF_ONE;
      end
    end

    // The writer follows the post-swap reader bank, so a same-cycle swap redirects it.
    wr_bank = ~rd_bank_d;

    if (wr_valid && wr_sof) begin
      short_d = (wr_state_q == WR_FILL);
      if (full_d[wr_bank]) begin
        full_d[wr_bank] = 1'b0;
        drop_d          = 1'b1;
      end
      wr_en_d    = 1'b1;
      wr_addr_d  = {wr_bank, OFF_ZERO};
      wr_off_d   = OFF_ONE;
      wr_state_d = WR_FILL;
    end else if (wr_valid && wr_state_q == WR_FILL) begin
      wr_en_d   = 1'b1;
      wr_addr_d = {wr_bank, wr_off_q};
      if (wr_off_q == LAST_OFF) begin
        full_d[wr_bank] = 1'b1;
        wr_off_d        = OFF_ZERO;
        wr_state_d      = WR_IDLE;
      end else begin
        wr_off_d = wr_off_q + OFF_ONE;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_state_q <= WR_IDLE;
      rd_state_q <= RD_IDLE;
      wr_off_q   <= '0;
      rd_off_q   <= '0;
      rd_bank_q  <= 1'b0;
      full_q     <= '0;
      rd_blank_q <= 1'b1;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      drop_q     <= 1'b0;
      repeat_q   <= 1'b0;
      short_q    <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      wr_off_q   <= wr_off_d;
      rd_off_q   <= rd_off_d;
      rd_bank_q  <= rd_bank_d;
      full_q     <= full_d;
      rd_blank_q <= rd_blank_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      drop_q     <= drop_d;
      repeat_q   <= repeat_d;
      short_q    <= short_d;
    end
  end

  assign mem_wr_en    = wr_en_q;
  assign mem_wr_addr  = wr_addr_q;
  assign mem_rd_en    = rd_en_q;
  assign mem_rd_addr  = rd_addr_q;
  assign rd_blank     = rd_blank_q;
  assign frame_drop   = drop_q;
  assign frame_repeat = repeat_q;
  assign wr_short     = short_q;

endmodule

// File: tb/tb_frame_buf_ctrl.sv
// Directed bench for frame_buf_ctrl with a 4-pixel frame: expected outputs are
// queued as each cycle's stimulus is driven and compared one cycle later.
`timescale 1ns/1ps
module tb_frame_buf_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_valid = 1'b0, wr_sof = 1'b0, rd_valid = 1'b0, rd_sof = 1'b0;
  logic       mem_wr_en, mem_rd_en, rd_blank, frame_drop, frame_repeat, wr_short;
  logic [3:0] mem_wr_addr, mem_rd_addr;

  typedef struct packed {
    logic       wen;
    logic [3:0] waddr;
    logic       ren;
    logic [3:0] raddr;
    logic       blank;
    logic       drop;
    logic       rep;
    logic       shrt;
  } exp_t;

  exp_t  sb_q[$];
  int    errors = 0;
  int    checks = 0;
  string cur_test = "";

  frame_buf_ctrl #(.FRAME_SIZE(4), .ADDR_WIDTH(4)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_sof(wr_sof), .rd_valid(rd_valid), .rd_sof(rd_sof),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .rd_blank(rd_blank), .frame_drop(frame_drop),
    .frame_repeat(frame_repeat), .wr_short(wr_short)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic exp_t ex(input logic wen, input logic [3:0] wa, input logic ren,
                              input logic [3:0] ra, input logic blank, input logic drop,
                              input logic rep, input logic shrt);
    exp_t e;
    e = '{wen: wen, waddr: wa, ren: ren, raddr: ra, blank: blank, drop: drop, rep: rep, shrt: shrt};
    return e;
  endfunction

  // Drive one cycle of stimulus, queue what must appear after the edge, then compare.
  task automatic step(input logic wv, input logic ws, input logic rv, input logic rs, input exp_t e);
    exp_t want;
    exp_t got;
    @(negedge clk);
    wr_valid = wv; wr_sof = ws; rd_valid = rv; rd_sof = rs;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    want = sb_q.pop_front();
    got  = '{wen: mem_wr_en, waddr: mem_wr_addr, ren: mem_rd_en, raddr: mem_rd_addr,
             blank: rd_blank, drop: frame_drop, rep: frame_repeat, shrt: wr_short};
    if (!want.wen) got.waddr = want.waddr;
    if (!want.ren) got.raddr = want.raddr;
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got wen=%b waddr=%h ren=%b raddr=%h blank=%b drop=%b rep=%b short=%b, want wen=%b waddr=%h ren=%b raddr=%h blank=%b drop=%b rep=%b short=%b",
               cur_test, got.wen, got.waddr, got.ren, got.raddr, got.blank, got.drop, got.rep, got.shrt,
               want.wen, want.waddr, want.ren, want.raddr, want.blank, want.drop, want.rep, want.shrt);
    end
  endtask

  task automatic test_reset();
    cur_test = "reset";
    repeat (3) @(negedge clk);
    reset = 1'b0;
    step(0, 0, 0, 0, ex(0, 4'h0, 0, 4'h0, 1, 0, 0, 0));
    cur_test = "rd_sof_no_frame";
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, ex(0, 4'h0, 0, 4'h0, 1, 0, 0, 0));
  endtask

  task automatic test_first_frame();
    cur_test = "first_write";
    step(1, 1, 0, 0, ex(1, 4'h8, 0, 4'h0, 1, 0, 0, 0));
    for (int i = 1; i < 4; i++) step(1, 0, 0, 0, ex(1, 4'(8 + i), 0, 4'h0, 1, 0, 0, 0));
    cur_test = "stray_wr_idle";
    step(1, 0, 0, 0, ex(0, 4'h0, 0, 4'h0, 1, 0, 0, 0));
    cur_test = "first_read_swap";
    step(0, 0, 1, 1, ex(0, 4'h0, 1, 4'h8, 0, 0, 0, 0));
    for (int i = 1; i < 4; i++) step(0, 0, 1, 0, ex(0, 4'h0, 1, 4'(8 + i), 0, 0, 0, 0));
    cur_test = "stray_rd_idle";
    step(0, 0, 1, 0, ex(0, 4'h0, 0, 4'h0, 0, 0, 0, 0));
  endtask

  task automatic test_drop();
    cur_test = "second_frame";
    step(1, 1, 0, 0, ex(1, 4'h0, 0, 4'h0, 0, 0, 0, 0));
    for (int i = 1; i < 4; i++) step(1, 0, 0, 0, ex(1, 4'(i), 0, 4'h0, 0, 0, 0, 0));
    cur_test = "third_frame_drop";
    step(1, 1, 0, 0, ex(1, 4'h0, 0, 4'h0, 0, 1, 0, 0));
    for (int i = 1; i < 4; i++) step(1, 0, 0, 0, ex(1, 4'(i), 0, 4'h0, 0, 0, 0, 0));
  endtask

  task automatic test_short();
    cur_test = "consume_bank0";
    step(0, 0, 1, 1, ex(0, 4'h0, 1, 4'h0, 0, 0, 0, 0));
    for (int i = 1; i < 4; i++) step(0, 0, 1, 0, ex(0, 4'h0, 1, 4'(i), 0, 0, 0, 0));
    cur_test = "short_frame";
    step(1, 1, 0, 0, ex(1, 4'h8, 0, 4'h0, 0, 0, 0, 0));
    step(1, 0, 0, 0, ex(1, 4'h9, 0, 4'h0, 0, 0, 0, 0));
    step(1, 1, 0, 0, ex(1, 4'h8, 0, 4'h0, 0, 0, 0, 1));
    cur_test = "repeat_after_short";
    step(0, 0, 1, 1, ex(0, 4'h0, 1, 4'h0, 0, 0, 1, 0));
    step(0, 0, 1, 0, ex(0, 4'h0, 1, 4'h1, 0, 0, 0, 0));
    cur_test = "finish_restarted";
    step(1, 0, 0, 0, ex(1, 4'h9, 0, 4'h0, 0, 0, 0, 0));
    step(1, 0, 0, 0, ex(1, 4'hA, 0, 4'h0, 0, 0, 0, 0));
    cur_test = "complete_with_rd_sof";
    step(1, 0, 1, 1, ex(1, 4'hB, 1, 4'h0, 0, 0, 1, 0));
  endtask

  task automatic test_back_to_back();
    cur_test = "swap_with_wr_sof";
    step(1, 1, 1, 1, ex(1, 4'h0, 1, 4'h8, 0, 0, 0, 0));
    step(1, 0, 1, 0, ex(1, 4'h1, 1, 4'h9, 0, 0, 0, 0));
  endtask

  task automatic test_reset_mid();
    cur_test = "pre_reset";
    step(1, 0, 1, 0, ex(1, 4'h2, 1, 4'hA, 0, 0, 0, 0));
    #1 reset = 1'b1;
    #1;
    checks++;
    if (mem_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_wr_en: got %b want 0", mem_wr_en);
    end
    checks++;
    if (mem_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_rd_en: got %b want 0", mem_rd_en);
    end
    checks++;
    if (rd_blank !== 1'b1) begin
      errors++;
      $display("FAIL async_reset_rd_blank: got %b want 1", rd_blank);
    end
    @(negedge clk);
    wr_valid = 1'b0; wr_sof = 1'b0; rd_valid = 1'b0; rd_sof = 1'b0;
    reset = 1'b0;
    cur_test = "post_reset_write";
    step(1, 1, 0, 0, ex(1, 4'h8, 0, 4'h0, 1, 0, 0, 0));
    cur_test = "post_reset_rd_sof";
    step(0, 0, 1, 1, ex(0, 4'h0, 0, 4'h0, 1, 0, 0, 0));
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_drop();
    test_short();
    test_back_to_back();
    test_reset_mid();
    @(negedge clk);
    wr_valid = 1'b0; wr_sof = 1'b0; rd_valid = 1'b0; rd_sof = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_buf_ctrl.md
Name: frame_buf_ctrl

Overview:
Double-buffer (ping-pong) address sequencer for the 24-bit frame buffer memory. Steers a pixel writer (camera/decoder side) and a pixel reader (display side) into two frame-sized banks. Generates registered memory enables and {bank, offset} addresses, and swaps banks only at read frame boundaries so the display never tears. Sits between the pixel sources and the frame_buf memory, single clock domain.

Parameters:
FRAME_SIZE, 307200, pixels per frame (640x480); legal range 2..2**(ADDR_WIDTH-1)
ADDR_WIDTH, 20, memory address width; MSB = bank select, low ADDR_WIDTH-1 bits = pixel offset

Ports:
clk  in  1  system clock, all logic rising-edge
reset  in  1  asynchronous, active-high; clears all state
wr_valid  in  1  writer presents one pixel this cycle
wr_sof  in  1  start of write frame; qualified by wr_valid, marks pixel 0
rd_valid  in  1  reader requests one pixel this cycle
rd_sof  in  1  start of read frame; qualified by rd_valid, marks pixel 0
mem_wr_en  out  1  write strobe to frame buffer memory
mem_wr_addr  out  ADDR_WIDTH  write address {wr_bank, wr_offset}
mem_rd_en  out  1  read strobe to frame buffer memory
mem_rd_addr  out  ADDR_WIDTH  read address {rd_bank, rd_offset}
rd_blank  out  1  high while the reader has no completed frame (display outputs black)
frame_drop  out  1  one-cycle pulse: completed-but-unread frame overwritten
frame_repeat  out  1  one-cycle pulse: rd_sof found no new frame, same bank re-read
wr_short  out  1  one-cycle pulse: write frame aborted by early wr_sof

Behaviour:
- Reset: all outputs 0 except rd_blank=1; rd_bank=0, full[1:0]=0, offsets 0, both FSMs IDLE.
- Write bank is always ~rd_bank, evaluated from the next-state rd_bank (a swap in the same cycle redirects the writer).
- Latency: one cycle from accepted request to mem_*_en/mem_*_addr; enables are strobes, low otherwise.
- Write FSM WR_IDLE / WR_FILL:
  - WR_IDLE: wr_valid without wr_sof is ignored (no strobe). wr_valid&wr_sof -> write offset 0; if full[wbank] then clear it and pulse frame_drop; go WR_FILL, offset 1.
  - WR_FILL: each wr_valid writes at offset and increments it. The write at offset FRAME_SIZE-1 sets full[wbank], offset->0, go WR_IDLE.
  - WR_FILL with wr_valid&wr_sof before the last pixel: pulse wr_short, restart at offset 0 in the same cycle (that pixel is written at offset 0); full stays clear.
  - wr_valid low: hold state, no strobe.
- Read FSM RD_IDLE / RD_SCAN:
  - rd_valid&rd_sof in any state:
    - If full[~rd_bank]: rd_bank<=~rd_bank, clear that full bit, rd_blank<=0.
    - Else if rd_blank=0: pulse frame_repeat.
    - Else (no frame ever completed): stay in RD_IDLE, rd_blank=1, no strobe.
    - Otherwise: read offset 0, go RD_SCAN, offset 1. rd_sof mid-scan restarts the same way.
  - RD_SCAN: each rd_valid reads at offset. The read at FRAME_SIZE-1 wraps offset to 0 and goes RD_IDLE. rd_valid without rd_sof in RD_IDLE gives no strobe.
- Simultaneous write completion and rd_sof in the same cycle: full is not yet visible, so the reader repeats; the swap happens at the next rd_sof.
- Simultaneous rd_sof swap and wr_sof: the writer targets the bank just released (old rd_bank); no drop pulse.
- The writer never writes the bank the reader holds. full[b] and "being written" are mutually exclusive.
- Reset mid-frame: immediate return to reset state; partially written data is abandoned (full=0).
- Arithmetic: offsets are ADDR_WIDTH-1 bits and compare against FRAME_SIZE-1 only; no modulo-2^n wrap is relied on.

Test Plan:
FRAME_SIZE=4, ADDR_WIDTH=4 for all directed tests.
- Reset then rd_sof+rd_valid x4, no writes -> rd_blank=1, mem_rd_en never asserted, no frame_repeat.
- Write pixels 1..4 (wr_sof on first) -> mem_wr_addr 0x8,0x9,0xA,0xB with mem_wr_en one cycle after each. Then rd_sof+4 reads -> rd_bank swaps to 1, mem_rd_addr 0x8..0xB, rd_blank falls to 0.
- Second frame written (to bank 0, 0x0..0x3), then a third frame started before any rd_sof -> frame_drop pulses on the third frame's first pixel, writes go to 0x0.
- wr_sof at pixel 2 of a frame -> wr_short pulse, next write at offset 0, full not set; a following rd_sof gives frame_repeat and reads the old bank.
- rd_sof same cycle as wr_sof with other bank full -> reader moves to that bank, writer's offset-0 write lands in the old reader bank, no frame_drop.
- Assert reset mid-WR_FILL and mid-RD_SCAN -> all enables drop asynchronously, rd_blank=1; next write frame targets bank 1 from offset 0.
